// File: rtl/pipelined_decode.sv
// LEGv8 decode stage for the pipelined core: field extraction, control decode,
// bypassed register-file read and an ID/EX register with load-use stall and flush.
module pipelined_decode #(
  parameter int  WORD      = 64,
  parameter int  INSTR_LEN = 32,
  parameter int  REG_COUNT = 32,
  parameter int  ZERO_REG  = 31,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_instruction,
  input  logic [WORD-1:0]      in_pc,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_reg,
  input  logic [WORD-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_pc,
  output logic [WORD-1:0]      out_read_data1,
  output logic [WORD-1:0]      out_read_data2,
  output logic [WORD-1:0]      out_imm,
  output logic [10:0]          out_opcode,
  output logic [AW-1:0]        out_rd,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_mem_to_reg,
  output logic                 out_alu_src,
  output logic                 out_reg_write,
  output logic                 out_update_sreg,
  output logic [2:0]           out_branch_op,
  output logic [1:0]           out_alu_op
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  localparam logic [7:0]  OP_BCND = 8'h54;
  localparam logic [5:0]  OP_B    = 6'h05;

  typedef enum logic [2:0] {IMM_NONE, IMM_D, IMM_I, IMM_CB, IMM_B} imm_sel_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       update_sreg;
    logic [2:0] branch_op;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t    ctrl;
    logic     uses_reg2;
    logic     reg2_is_rd;
    imm_sel_e imm_sel;
  } dec_t;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] rd1;
    logic [WORD-1:0] rd2;
    logic [WORD-1:0] imm;
    logic [10:0]     opcode;
    logic [AW-1:0]   rd;
    ctrl_t           ctrl;
  } idex_t;

  function automatic dec_t decode(input logic [INSTR_LEN-1:0] ins);
    dec_t d;
    d = '0;
    if (ins[31:21] inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS}) begin
      d.ctrl.reg_write   = 1'b1;
      d.ctrl.alu_op      = 2'b10;
      d.ctrl.update_sreg = (ins[31:21] == OP_ADDS) || (ins[31:21] == OP_SUBS);
      d.uses_reg2        = 1'b1;
    end else if (ins[31:21] == OP_LDUR) begin
      d.ctrl.mem_read    = 1'b1;
      d.ctrl.mem_to_reg  = 1'b1;
      d.ctrl.alu_src     = 1'b1;
      d.ctrl.reg_write   = 1'b1;
      d.imm_sel          = IMM_D;
    end else if (ins[31:21] == OP_STUR) begin
      // Stores read the data register through the rd field.
      d.ctrl.mem_write   = 1'b1;
      d.ctrl.alu_src     = 1'b1;
      d.uses_reg2        = 1'b1;
      d.reg2_is_rd       = 1'b1;
      d.imm_sel          = IMM_D;
    end else if ((ins[31:22] == OP_ADDI) || (ins[31:22] == OP_SUBI)) begin
      d.ctrl.alu_src     = 1'b1;
      d.ctrl.reg_write   = 1'b1;
      d.imm_sel          = IMM_I;
    end else if ((ins[31:24] == OP_CBZ) || (ins[31:24] == OP_CBNZ)) begin
      d.ctrl.alu_op      = 2'b01;
      d.ctrl.branch_op   = (ins[31:24] == OP_CBZ) ? 3'b010 : 3'b011;
      d.uses_reg2        = 1'b1;
      d.reg2_is_rd       = 1'b1;
      d.imm_sel          = IMM_CB;
    end else if (ins[31:24] == OP_BCND) begin
      d.ctrl.branch_op   = 3'b100;
      d.imm_sel          = IMM_CB;
    end else if (ins[31:26] == OP_B) begin
      d.ctrl.branch_op   = 3'b001;
      d.imm_sel          = IMM_B;
    end
    return d;
  endfunction

  function automatic logic [WORD-1:0] ext_imm(input imm_sel_e sel,
                                              input logic [INSTR_LEN-1:0] ins);
    logic [WORD-1:0] v;
    case (sel)
      IMM_D:   v = {{(WORD-9){ins[20]}}, ins[20:12]};
      IMM_I:   v = {{(WORD-12){1'b0}}, ins[21:10]};
      IMM_CB:  v = {{(WORD-19){ins[23]}}, ins[23:5]};
      IMM_B:   v = {{(WORD-26){ins[25]}}, ins[25:0]};
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [WORD-1:0] rf_q [REG_COUNT];
  idex_t           idex_q, idex_d;
  logic            vld_q;

  dec_t            dec;
  logic [AW-1:0]   rd_idx, rn_idx, rm_idx, rr2_idx;
  logic [WORD-1:0] rdata1, rdata2;
  logic            hazard, accept;

  // ---- decode / operand read (combinational, same cycle as fetch handoff) ----
  assign dec     = decode(in_instruction);
  assign rd_idx  = in_instruction[AW-1:0];
  assign rn_idx  = in_instruction[5 +: AW];
  assign rm_idx  = in_instruction[16 +: AW];
  assign rr2_idx = dec.reg2_is_rd ? rd_idx : rm_idx;

  always_comb begin
    rdata1 = rf_q[rn_idx];
    if (rn_idx == ZR)                         rdata1 = '0;
    else if (wb_en && (wb_reg == rn_idx))     rdata1 = wb_data;
    rdata2 = rf_q[rr2_idx];
    if (rr2_idx == ZR)                        rdata2 = '0;
    else if (wb_en && (wb_reg == rr2_idx))    rdata2 = wb_data;
  end

  // A load in ID/EX cannot forward to a consumer one slot behind it.
  assign hazard = vld_q && idex_q.ctrl.mem_read && (idex_q.rd != ZR) &&
                  ((idex_q.rd == rn_idx) || (dec.uses_reg2 && (idex_q.rd == rr2_idx)));

  assign in_ready = !reset && !flush && !hazard && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    idex_d.pc     = in_pc;
    idex_d.rd1    = rdata1;
    idex_d.rd2    = rdata2;
    idex_d.imm    = ext_imm(dec.imm_sel, in_instruction);
    idex_d.opcode = in_instruction[31:21];
    idex_d.rd     = rd_idx;
    idex_d.ctrl   = dec.ctrl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_reg != ZR)) begin
      rf_q[wb_reg] <= wb_data;
    end
  end

  // ---- ID/EX register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      idex_q <= '0;
    end else if (flush) begin
      vld_q  <= 1'b0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      idex_q <= idex_d;
    end else if (out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign out_valid       = vld_q;
  assign out_pc          = idex_q.pc;
  assign out_read_data1  = idex_q.rd1;
  assign out_read_data2  = idex_q.rd2;
  assign out_imm         = idex_q.imm;
  assign out_opcode      = idex_q.opcode;
  assign out_rd          = idex_q.rd;
  assign out_mem_read    = idex_q.ctrl.mem_read;
  assign out_mem_write   = idex_q.ctrl.mem_write;
  assign out_mem_to_reg  = idex_q.ctrl.mem_to_reg;
  assign out_alu_src     = idex_q.ctrl.alu_src;
  assign out_reg_write   = idex_q.ctrl.reg_write;
  assign out_update_sreg = idex_q.ctrl.update_sreg;
  assign out_branch_op   = idex_q.ctrl.branch_op;
  assign out_alu_op      = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_pipelined_decode.sv
// Scoreboard bench for pipelined_decode: instructions are built from mnemonics,
// expected ID/EX contents come from a mnemonic-level model and are checked by a monitor.
module tb_pipelined_decode;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] in_instruction;
  logic [63:0] in_pc, wb_data;
  logic [4:0]  wb_reg;
  logic [63:0] out_pc, out_read_data1, out_read_data2, out_imm;
  logic [10:0] out_opcode;
  logic [4:0]  out_rd;
  logic        out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src, out_reg_write, out_update_sreg;
  logic [2:0]  out_branch_op;
  logic [1:0]  out_alu_op;

  pipelined_decode dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_read_data1(out_read_data1), .out_read_data2(out_read_data2), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_rd(out_rd),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_alu_src(out_alu_src), .out_reg_write(out_reg_write), .out_update_sreg(out_update_sreg),
    .out_branch_op(out_branch_op), .out_alu_op(out_alu_op)
  );

  typedef enum int {K_ADD, K_SUB, K_AND, K_ORR, K_ADDS, K_SUBS, K_ADDI, K_SUBI,
                    K_LDUR, K_STUR, K_CBZ, K_CBNZ, K_B, K_BCOND, K_NOP} kind_e;

  typedef struct packed {
    logic [63:0] pc, rd1, rd2, imm;
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic        mem_read, mem_write, mem_to_reg, alu_src, reg_write, update_sreg;
    logic [2:0]  br;
    logic [1:0]  alu;
  } obs_t;

  obs_t        sb_q[$];
  logic [63:0] model_rf [32];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  obs_t        mon_a;
  logic [63:0] pc_ctr = 64'h1000;

  task automatic check(input bit ok, input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] encode(kind_e k, int rd, int rn, int rm, int imm);
    logic [4:0]  d  = rd[4:0];
    logic [4:0]  n  = rn[4:0];
    logic [4:0]  m  = rm[4:0];
    logic [31:0] iv = imm;
    logic [31:0] w;
    case (k)
      K_ADD:   w = {11'h458, m, 6'd0, n, d};
      K_SUB:   w = {11'h658, m, 6'd0, n, d};
      K_AND:   w = {11'h450, m, 6'd0, n, d};
      K_ORR:   w = {11'h550, m, 6'd0, n, d};
      K_ADDS:  w = {11'h558, m, 6'd0, n, d};
      K_SUBS:  w = {11'h758, m, 6'd0, n, d};
      K_ADDI:  w = {10'h244, iv[11:0], n, d};
      K_SUBI:  w = {10'h344, iv[11:0], n, d};
      K_LDUR:  w = {11'h7C2, iv[8:0], 2'b00, n, d};
      K_STUR:  w = {11'h7C0, iv[8:0], 2'b00, n, d};
      K_CBZ:   w = {8'hB4, iv[18:0], d};
      K_CBNZ:  w = {8'hB5, iv[18:0], d};
      K_B:     w = {6'h05, iv[25:0]};
      K_BCOND: w = {8'h54, iv[18:0], d};
      default: w = {11'h000, m, iv[5:0], n, d};
    endcase
    return w;
  endfunction

  function automatic int rand_imm(kind_e k);
    case (k)
      K_ADDI, K_SUBI:         return int'($urandom_range(0, 4095));
      K_LDUR, K_STUR:         return int'($urandom_range(0, 511)) - 256;
      K_CBZ, K_CBNZ, K_BCOND: return int'($urandom_range(0, 524287)) - 262144;
      K_B:                    return int'($urandom_range(0, 67108863)) - 33554432;
      default:                return int'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic int pick_reg();
    int r = int'($urandom_range(0, 9));
    if (r < 8) return r;
    if (r == 8) return 31;
    return int'($urandom_range(0, 31));
  endfunction

  function automatic logic [63:0] model_read(logic [4:0] r);
    if (r == 5'd31) return 64'd0;
    if (wb_en && wb_reg == r) return wb_data;
    return model_rf[r];
  endfunction

  function automatic obs_t expect_of(kind_e k, logic [31:0] w, int imm, logic [63:0] pc,
                                     logic [63:0] a, logic [63:0] b);
    obs_t  e = '0;
    longint simm = longint'(imm);
    e.pc = pc; e.rd1 = a; e.rd2 = b; e.opcode = w[31:21]; e.rd = w[4:0];
    case (k)
      K_ADD, K_SUB, K_AND, K_ORR: begin e.reg_write = 1; e.alu = 2'b10; end
      K_ADDS, K_SUBS: begin e.reg_write = 1; e.alu = 2'b10; e.update_sreg = 1; end
      K_ADDI, K_SUBI: begin e.alu_src = 1; e.reg_write = 1; e.imm = simm; end
      K_LDUR: begin e.mem_read = 1; e.mem_to_reg = 1; e.alu_src = 1; e.reg_write = 1; e.imm = simm; end
      K_STUR: begin e.mem_write = 1; e.alu_src = 1; e.imm = simm; end
      K_CBZ:  begin e.alu = 2'b01; e.br = 3'b010; e.imm = simm; end
      K_CBNZ: begin e.alu = 2'b01; e.br = 3'b011; e.imm = simm; end
      K_B:    begin e.br = 3'b001; e.imm = simm; end
      K_BCOND: begin e.br = 3'b100; e.imm = simm; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cycle(input bit rst, input bit fl, input bit iv, input kind_e k, input logic [31:0] w,
                       input int imm, input bit ordy, input bit we, input logic [4:0] wr,
                       input logic [63:0] wd);
    bit         haz, pred, acc, uses2;
    logic [4:0] rn, rs2;
    obs_t       e;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; in_instruction = w; in_pc = pc_ctr;
    out_ready = ordy; wb_en = we; wb_reg = wr; wb_data = wd;
    #1;
    rn    = w[9:5];
    uses2 = k inside {K_ADD, K_SUB, K_AND, K_ORR, K_ADDS, K_SUBS, K_STUR, K_CBZ, K_CBNZ};
    rs2   = (k inside {K_STUR, K_CBZ, K_CBNZ}) ? w[4:0] : w[20:16];
    haz   = 1'b0;
    if (sb_q.size() != 0)
      haz = sb_q[0].mem_read && sb_q[0].rd != 5'd31 &&
            (sb_q[0].rd == rn || (uses2 && sb_q[0].rd == rs2));
    pred = !rst && !fl && !haz && (sb_q.size() == 0 || ordy);
    check(in_ready === pred, "in_ready", 320'(in_ready), 320'(pred));
    acc = iv && pred;
    e = '0;
    if (acc) e = expect_of(k, w, imm, pc_ctr, model_read(rn), model_read(rs2));
    @(posedge clk);
    if (rst) begin
      sb_q.delete();
      for (int i = 0; i < 32; i++) model_rf[i] = 64'd0;
    end else begin
      if (fl) sb_q.delete();
      else if (acc) sb_q.push_back(e);
      if (we && wr != 5'd31) model_rf[wr] = wd;
    end
    if (acc) pc_ctr = pc_ctr + 64'd4;
  endtask

  task automatic op(input kind_e k, input int rd, input int rn, input int rm, input int imm,
                    input bit ordy);
    cycle(0, 0, 1, k, encode(k, rd, rn, rm, imm), imm, ordy, 0, 5'd0, 64'd0);
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      mon_a = {out_pc, out_read_data1, out_read_data2, out_imm, out_opcode, out_rd,
               out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src, out_reg_write,
               out_update_sreg, out_branch_op, out_alu_op};
      if (sb_q.size() == 0) begin
        check(out_valid === 1'b0, "idle_valid", 320'(out_valid), 320'(0));
      end else begin
        check(out_valid === 1'b1, "out_valid", 320'(out_valid), 320'(1));
        check(mon_a === sb_q[0], "idex_fields", 320'(mon_a), 320'(sb_q[0]));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    kind_e k;
    int    imm;
    reset = 1; flush = 0; in_valid = 0; in_instruction = 0; in_pc = 0;
    out_ready = 0; wb_en = 0; wb_reg = 0; wb_data = 0;

    // Reset with an instruction offered: nothing accepted, ID/EX cleared.
    cycle(1, 0, 1, K_ADD, encode(K_ADD, 1, 2, 3, 0), 0, 1, 0, 5'd0, 64'd0);
    #1;
    mon_a = {out_pc, out_read_data1, out_read_data2, out_imm, out_opcode, out_rd,
             out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src, out_reg_write,
             out_update_sreg, out_branch_op, out_alu_op};
    check(out_valid === 1'b0 && mon_a === '0, "reset_state", 320'({out_valid, mon_a}), 320'(0));
    mon_en = 1'b1;

    op(K_ADD, 1, 5, 5, 0, 1);                                    // X5 reads 0 after reset
    cycle(0, 0, 1, K_ADD, encode(K_ADD, 1, 3, 4, 0), 0, 1, 1, 5'd3, 64'hDEAD);  // bypass

    // Load-use: stall one cycle, then the ADD sees X2 forwarded from write-back.
    op(K_LDUR, 2, 1, 0, 8, 1);
    op(K_ADD, 5, 2, 6, 0, 1);
    cycle(0, 0, 1, K_ADD, encode(K_ADD, 5, 2, 6, 0), 0, 1, 1, 5'd2, 64'h77);
    cycle(0, 0, 0, K_NOP, 32'd0, 0, 1, 0, 5'd0, 64'd0);

    // Backpressure: SUBI held for three cycles, then the waiting ADD enters at release.
    op(K_SUBI, 7, 7, 0, 1, 1);
    for (int i = 0; i < 3; i++) op(K_ADD, 8, 7, 1, 0, 0);
    op(K_ADD, 8, 7, 1, 0, 1);
    cycle(0, 0, 0, K_NOP, 32'd0, 0, 1, 0, 5'd0, 64'd0);

    // Zero register: write to X31 is discarded, CBZ X31 reads 0.
    cycle(0, 0, 1, K_CBZ, encode(K_CBZ, 31, 0, 0, -4), -4, 1, 1, 5'd31, 64'h55);
    op(K_STUR, 31, 31, 0, -1, 1);

    // Flush while holding, with a coincident write-back that must still land.
    op(K_ADD, 8, 1, 2, 0, 0);
    cycle(1'b0, 1'b1, 1'b1, K_ADD, encode(K_ADD, 9, 1, 1, 0), 0, 0, 1, 5'd9, 64'h1234);
    op(K_ADD, 10, 9, 9, 0, 1);
    cycle(0, 0, 0, K_NOP, 32'd0, 0, 1, 0, 5'd0, 64'd0);

    for (int n = 0; n < 800; n++) begin
      k   = kind_e'($urandom_range(0, 14));
      imm = rand_imm(k);
      cycle($urandom_range(0, 96) == 0, $urandom_range(0, 12) == 0, $urandom_range(0, 3) != 0,
            k, encode(k, pick_reg(), pick_reg(), pick_reg(), imm), imm,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 5'(pick_reg()),
            {$urandom, $urandom});
    end

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, K_NOP, 32'd0, 0, 1, 0, 5'd0, 64'd0);
    #3;
    check(sb_q.size() == 0, "drain", 320'(sb_q.size()), 320'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_decode.md
Name: pipelined_decode

Overview:
- Parametrised successor of the single-cycle LEGv8 decode stage, for the pipelined core.
- Parses the instruction, generates control, and reads its internal register file with write-back bypass.
- Sign-extends the immediate per format and registers everything into an ID/EX output register with a valid/ready handshake.
- Detects load-use hazards, inserts a one-cycle bubble, and supports flush.

Parameters:
- WORD, 64, datapath width in bits.
- INSTR_LEN, 32, instruction width.
- REG_COUNT, 32, number of architectural registers (index width = clog2(REG_COUNT)).
- ZERO_REG, 31, register index that always reads 0; writes to it are discarded.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  discard held and incoming instruction
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  decode accepts this cycle
- in_instruction  input  INSTR_LEN  instruction word
- in_pc  input  WORD  PC of the instruction
- wb_en  input  1  write-back enable
- wb_reg  input  clog2(REG_COUNT)  write-back destination
- wb_data  input  WORD  write-back value
- out_valid  output  1  ID/EX register holds a valid instruction
- out_ready  input  1  execute consumes this cycle
- out_pc, out_read_data1, out_read_data2, out_imm  output  WORD  registered operands and sign-extended immediate
- out_opcode  output  11  instruction[31:21]
- out_rd  output  clog2(REG_COUNT)  destination index
- out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src, out_reg_write, out_update_sreg  output  1  control
- out_branch_op  output  3  000 none, 001 B, 010 CBZ, 011 CBNZ, 100 B.cond
- out_alu_op  output  2  00 add, 01 pass-B/compare-zero, 10 R-type funct

Behaviour:
- Reset (sync): out_valid=0; all out_* fields=0; all registers=0; in_ready=0 during the reset cycle.
- Field extraction: rd=[4:0], rn=[9:5], rm=[20:16]. read_reg2=rd for STUR/CBZ/CBNZ, else rm.
- Immediates:
  - D-format [20:12] sign-extended.
  - I-format [21:10] zero-extended.
  - CB [23:5] sign-extended.
  - B [25:0] sign-extended.
  - R-format: 0.
- Control decode:
  - R-type (ADD/SUB/AND/ORR, ADDS/SUBS set update_sreg): reg_write=1, alu_op=10.
  - ADDI/SUBI: alu_src=1, reg_write=1, alu_op=00.
  - LDUR: mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1.
  - STUR: mem_write=1, alu_src=1.
  - CBZ/CBNZ: alu_op=01.
  - B: branch_op=001.
  - Unknown opcode: all control 0 (NOP).
- Register file:
  - Write on the clk edge when wb_en && wb_reg!=ZERO_REG.
  - Reads are combinational.
  - Bypass: if wb_en && wb_reg==rs && rs!=ZERO_REG, the read returns wb_data in the same cycle.
  - ZERO_REG always reads 0.
- Hazard:
  - hazard = out_valid && out_mem_read && out_rd!=ZERO_REG && (out_rd==rn || (out_rd==read_reg2 && instruction uses reg2)).
  - reg2 is used by R-type, STUR, CBZ, CBNZ.
- Handshake:
  - in_ready = !reset && !flush && !hazard && (!out_valid || out_ready).
  - Accept (in_valid && in_ready): latency 1; the out register loads decoded fields on that edge, out_valid=1.
  - out_valid && out_ready with no accept: out_valid<=0 (bubble).
  - out_valid && !out_ready: out register holds all fields stable.
- Load-use: while hazard=1, the load drains on out_ready, leaving one bubble cycle. The dependent instruction is accepted the following cycle, reading the forwarded/written value.
- Flush: out_valid<=0 next edge, in_instruction not accepted; register file writes still occur.
- Reset/flush mid-operation: the held instruction is lost; no partial state remains.
- Simultaneous wb write and read of the same register: bypass value used, register updated.

Test Plan:
- Reset: assert reset 1 cycle with in_valid=1 → out_valid=0, in_ready=0. Reading X5 afterwards → 0.
- Write-back bypass: wb_en=1, wb_reg=3, wb_data=0xDEAD, same cycle as ADD X1,X3,X4 accepted → next cycle out_read_data1=0xDEAD, out_reg_write=1, out_alu_op=10.
- Load-use: LDUR X2,[X1,#8] accepted, then ADD X5,X2,X6 presented, out_ready=1 → in_ready=0 one cycle. The bubble cycle shows out_valid=0, and the ADD appears the cycle after; out_imm of LDUR=8.
- Backpressure: out_ready=0 for 3 cycles with SUBI X7,X7,#1 held → all out_* stable, in_ready=0. Release → next instruction accepted same cycle.
- Zero register: wb_en=1, wb_reg=31, wb_data=0x55, then CBZ X31,#-4 → out_read_data2=0, out_imm=0xFFFF_FFFF_FFFF_FFFC, out_branch_op=010.
- Flush: flush=1 while out_valid=1 and in_valid=1 → out_valid=0 next cycle, instruction not accepted. Flush coincident with wb_en → write still lands.
